// File: rtl/memory_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_unit_pkg
// Shared constants, the decoded memory-operation type and small helpers for
// the RV32I load/store stage (memory_access_unit and load_store_lane_align).
// No ports; imported with `import memory_access_unit_pkg::*;`.
// -----------------------------------------------------------------------------
package memory_access_unit_pkg;

  localparam int unsigned X_LENGTH     = 32;
  localparam int unsigned MEMORY_DEPTH = 10;
  localparam int unsigned MEMORY_WIDTH = 32;

  // One value per access kind after priority resolution of the decode strobes.
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_SW   = 4'd1,
    OP_SH   = 4'd2,
    OP_SB   = 4'd3,
    OP_LW   = 4'd4,
    OP_LH   = 4'd5,
    OP_LHU  = 4'd6,
    OP_LB   = 4'd7,
    OP_LBU  = 4'd8
  } mem_op_e;

  // Sign-extend a 12-bit I/S-type immediate to the datapath width.
  function automatic logic [X_LENGTH-1:0] sext12(input logic [11:0] imm);
    return {{(X_LENGTH-12){imm[11]}}, imm};
  endfunction

  function automatic logic is_store_op(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_load_op(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/memory_access_unit_load_store_lane_align.sv
// -----------------------------------------------------------------------------
// load_store_lane_align
// Purely combinational lane handling for the load/store stage.
//   op_i         : resolved memory operation
//   offset_i     : byte offset inside the word (ea[1:0])
//   rdata_i      : word currently read from memory
//   wdata_i      : store data (rs2)
//   store_word_o : rdata_i with the addressed byte/half replaced (sb/sh),
//                  or wdata_i (sw); rdata_i for non-stores
//   load_word_o  : extracted and sign/zero-extended load value; 0 for
//                  non-loads
// -----------------------------------------------------------------------------
module load_store_lane_align
  import memory_access_unit_pkg::*;
(
  input  mem_op_e               op_i,
  input  logic [1:0]            offset_i,
  input  logic [X_LENGTH-1:0]   rdata_i,
  input  logic [X_LENGTH-1:0]   wdata_i,
  output logic [X_LENGTH-1:0]   store_word_o,
  output logic [X_LENGTH-1:0]   load_word_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction: byte by full offset, half by offset[1] only.
  always_comb begin
    byte_s = rdata_i[{offset_i, 3'b000} +: 8];
    if (offset_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Store merge: read-modify-write of the addressed lane.
  always_comb begin
    store_word_o = rdata_i;
    case (op_i)
      OP_SB: store_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      OP_SH: begin
        if (offset_i[1]) begin
          store_word_o[31:16] = wdata_i[15:0];
        end else begin
          store_word_o[15:0] = wdata_i[15:0];
        end
      end
      OP_SW:   store_word_o = wdata_i;
      default: store_word_o = rdata_i;
    endcase
  end

  // Load extension.
  always_comb begin
    load_word_o = {X_LENGTH{1'b0}};
    case (op_i)
      OP_LB:   load_word_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_word_o = {24'h000000, byte_s};
      OP_LH:   load_word_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_word_o = {16'h0000, half_s};
      OP_LW:   load_word_o = rdata_i;
      default: load_word_o = {X_LENGTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// RV32I load/store stage between execute and write-back. Computes the
// effective address, drives an asynchronous-read word memory, performs
// read-modify-write for sb/sh/sw and registers load results.
//
// Ports:
//   clk, rst_n                     clock; rst_n is an ACTIVE-HIGH async reset
//   rv32_s_sb/sh/sw                store strobes
//   rv32_i_lb/lh/lw/lbu/lhu        load strobes
//   rv32_i_imm_11_0 / rv32_s_imm_11_0  signed load / store offsets
//   operand_1 / operand_2          base address / store data
//   operand_3                      reserved, ignored
//   write_back_register_rd_data    registered load result (1-cycle latency)
//   memory_read_address            word address of the access (0 when idle)
//   memory_read_data               asynchronous read data
//   memory_write_address/data/enable  store port (zeroed when idle)
//   misaligned_fault               only with MEMORY_ACCESS_MISALIGN_CHECK_EN
//
// Optional feature macro: MEMORY_ACCESS_MISALIGN_CHECK_EN
//   Flags misaligned half/word accesses, suppresses their write/load result
//   and adds the registered misaligned_fault output.
// -----------------------------------------------------------------------------
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned X_LENGTH     = memory_access_unit_pkg::X_LENGTH,
  parameter int unsigned MEMORY_DEPTH = memory_access_unit_pkg::MEMORY_DEPTH,
  parameter int unsigned MEMORY_WIDTH = memory_access_unit_pkg::MEMORY_WIDTH
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rv32_s_sb,
  input  logic                    rv32_s_sh,
  input  logic                    rv32_s_sw,
  input  logic                    rv32_i_lb,
  input  logic                    rv32_i_lh,
  input  logic                    rv32_i_lw,
  input  logic                    rv32_i_lbu,
  input  logic                    rv32_i_lhu,
  input  logic [11:0]             rv32_i_imm_11_0,
  input  logic [11:0]             rv32_s_imm_11_0,
  input  logic [X_LENGTH-1:0]     operand_1,
  input  logic [X_LENGTH-1:0]     operand_2,
  input  logic [X_LENGTH-1:0]     operand_3,
  output logic [X_LENGTH-1:0]     write_back_register_rd_data,
  output logic [MEMORY_DEPTH-1:0] memory_read_address,
  input  logic [MEMORY_WIDTH-1:0] memory_read_data,
  output logic [MEMORY_DEPTH-1:0] memory_write_address,
  output logic [MEMORY_WIDTH-1:0] memory_write_data,
  output logic                    memory_write_enable
`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  ,
  output logic                    misaligned_fault
`endif
);

  mem_op_e             op_s;
  logic                is_store_s;
  logic                is_load_s;
  logic [X_LENGTH-1:0] ea_s;
  logic [MEMORY_DEPTH-1:0] word_addr_s;
  logic                misaligned_s;
  logic [X_LENGTH-1:0] store_word_s;
  logic [X_LENGTH-1:0] load_word_s;
  logic [X_LENGTH-1:0] rd_data_d;
  logic [X_LENGTH-1:0] rd_data_q;
  logic                unused_s;

  // Priority decode of the strobes: sw > sh > sb > lw > lh > lhu > lb > lbu.
  always_comb begin
    op_s = OP_NONE;
    if (rv32_s_sw) begin
      op_s = OP_SW;
    end else if (rv32_s_sh) begin
      op_s = OP_SH;
    end else if (rv32_s_sb) begin
      op_s = OP_SB;
    end else if (rv32_i_lw) begin
      op_s = OP_LW;
    end else if (rv32_i_lh) begin
      op_s = OP_LH;
    end else if (rv32_i_lhu) begin
      op_s = OP_LHU;
    end else if (rv32_i_lb) begin
      op_s = OP_LB;
    end else if (rv32_i_lbu) begin
      op_s = OP_LBU;
    end else begin
      op_s = OP_NONE;
    end
  end

  assign is_store_s = is_store_op(op_s);
  assign is_load_s  = is_load_op(op_s);

  // Effective address; stores take the S-type offset, everything else I-type.
  always_comb begin
    if (is_store_s) begin
      ea_s = operand_1 + sext12(rv32_s_imm_11_0);
    end else begin
      ea_s = operand_1 + sext12(rv32_i_imm_11_0);
    end
  end

  // Bits above the memory range are discarded.
  assign word_addr_s = ea_s[MEMORY_DEPTH+1:2];

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  // Half accesses must be 2-aligned, word accesses 4-aligned.
  always_comb begin
    case (op_s)
      OP_SH, OP_LH, OP_LHU: misaligned_s = ea_s[0];
      OP_SW, OP_LW:         misaligned_s = (ea_s[1:0] != 2'b00);
      default:              misaligned_s = 1'b0;
    endcase
  end
`else
  assign misaligned_s = 1'b0;
`endif

  load_store_lane_align u_lane_align (
    .op_i         (op_s),
    .offset_i     (ea_s[1:0]),
    .rdata_i      (memory_read_data),
    .wdata_i      (operand_2),
    .store_word_o (store_word_s),
    .load_word_o  (load_word_s)
  );

  // Memory-side outputs; write enable is also gated by reset.
  always_comb begin
    if (op_s != OP_NONE) begin
      memory_read_address = word_addr_s;
    end else begin
      memory_read_address = {MEMORY_DEPTH{1'b0}};
    end
    if (is_store_s) begin
      memory_write_address = word_addr_s;
      memory_write_data    = store_word_s;
      memory_write_enable  = ~misaligned_s & ~rst_n;
    end else begin
      memory_write_address = {MEMORY_DEPTH{1'b0}};
      memory_write_data    = {MEMORY_WIDTH{1'b0}};
      memory_write_enable  = 1'b0;
    end
  end

  // Next write-back value: loaded word for good loads, zero otherwise.
  always_comb begin
    if (is_load_s && !misaligned_s) begin
      rd_data_d = load_word_s;
    end else begin
      rd_data_d = {X_LENGTH{1'b0}};
    end
  end

  // Write-back register; reset discards any load in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_data_q <= {X_LENGTH{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign write_back_register_rd_data = rd_data_q;

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  logic fault_q;

  // Fault flag aligned with the write-back register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= misaligned_s;
    end
  end

  assign misaligned_fault = fault_q;
`endif

  // Reserved operand and discarded high address bits are intentionally unused.
  assign unused_s = ^{operand_3, ea_s[X_LENGTH-1:MEMORY_DEPTH+2]};

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
// Directed vectors with hand-computed expectations. The driver applies each
// vector on the falling edge and queues its expected response; a monitor pops
// the queue 1 time unit after the following rising edge, where both the
// combinational memory outputs (inputs still held) and the registered
// write-back value belong to that same vector.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam logic [7:0] S_SW  = 8'h80;
  localparam logic [7:0] S_SH  = 8'h40;
  localparam logic [7:0] S_SB  = 8'h20;
  localparam logic [7:0] S_LW  = 8'h10;
  localparam logic [7:0] S_LH  = 8'h08;
  localparam logic [7:0] S_LHU = 8'h04;
  localparam logic [7:0] S_LB  = 8'h02;
  localparam logic [7:0] S_LBU = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  strb;
  logic [11:0] iimm, simm;
  logic [31:0] op1, op2, op3, rdata;
  logic [31:0] rd_data;
  logic [9:0]  raddr, waddr;
  logic [31:0] wdata;
  logic        we;
  logic        fault;

  typedef struct {
    string       nm;
    logic [9:0]  raddr;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .rv32_s_sb                   (strb[5]),
    .rv32_s_sh                   (strb[6]),
    .rv32_s_sw                   (strb[7]),
    .rv32_i_lb                   (strb[1]),
    .rv32_i_lh                   (strb[3]),
    .rv32_i_lw                   (strb[4]),
    .rv32_i_lbu                  (strb[0]),
    .rv32_i_lhu                  (strb[2]),
    .rv32_i_imm_11_0             (iimm),
    .rv32_s_imm_11_0             (simm),
    .operand_1                   (op1),
    .operand_2                   (op2),
    .operand_3                   (op3),
    .write_back_register_rd_data (rd_data),
    .memory_read_address         (raddr),
    .memory_read_data            (rdata),
    .memory_write_address        (waddr),
    .memory_write_data           (wdata),
    .memory_write_enable         (we)
`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
    ,
    .misaligned_fault            (fault)
`endif
  );

`ifndef MEMORY_ACCESS_MISALIGN_CHECK_EN
  assign fault = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input string nm, input logic [7:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [11:0] ii, input logic [11:0] si,
                       input logic [31:0] rdw, input logic [9:0] e_ra, input logic [9:0] e_wa,
                       input logic [31:0] e_wd, input logic e_we, input logic [31:0] e_rd,
                       input logic e_flt);
    exp_t e;
    @(negedge clk);
    strb = s; op1 = a; op2 = d; iimm = ii; simm = si; rdata = rdw;
    op3 = 32'hFFFF_FFFF;
    e.nm = nm; e.raddr = e_ra; e.waddr = e_wa; e.wdata = e_wd;
    e.we = e_we; e.rd = e_rd; e.flt = e_flt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the queued expectation against the DUT after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.nm, ".raddr"}, {22'd0, raddr}, {22'd0, e.raddr});
        chk({e.nm, ".waddr"}, {22'd0, waddr}, {22'd0, e.waddr});
        chk({e.nm, ".wdata"}, wdata, e.wdata);
        chk({e.nm, ".we"}, {31'd0, we}, {31'd0, e.we});
        chk({e.nm, ".rd"}, rd_data, e.rd);
`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
        chk({e.nm, ".fault"}, {31'd0, fault}, {31'd0, e.flt});
`endif
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 1'b1;
    strb = S_SB; op1 = 32'd0; op2 = 32'd1; op3 = 32'd0;
    iimm = 12'd0; simm = 12'd0; rdata = 32'hAABB_CCDD;
    #2;
    chk("rst.rd", rd_data, 32'd0);
    chk("rst.we", {31'd0, we}, 32'd0);
    chk("rst.wdata_comb", wdata, 32'hAABB_CC01);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    strb = 8'h00; op2 = 32'd0; rdata = 32'd0;

    //    name        strobes        op1           op2           iimm     simm     rdata         raddr   waddr   wdata         we          rd            fault
    drive("sb0",      S_SB,          32'h0,        32'h1,        12'h000, 12'h000, 32'hAABBCCDD, 10'd0,  10'd0,  32'hAABBCC01, 1'b1,       32'h0,        1'b0);
    drive("idle",     8'h00,         32'h0,        32'h0,        12'h000, 12'h000, 32'h0,        10'd0,  10'd0,  32'h0,        1'b0,       32'h0,        1'b0);
    drive("sh_hi",    S_SH,          32'h102,      32'h1234,     12'h000, 12'h000, 32'h11223344, 10'h40, 10'h40, 32'h12343344, 1'b1,       32'h0,        1'b0);
    drive("sw_neg",   S_SW,          32'h10,       32'hDEADBEEF, 12'h000, 12'hFFC, 32'h0,        10'd3,  10'd3,  32'hDEADBEEF, 1'b1,       32'h0,        1'b0);
    drive("sb_hibit", S_SB,          32'h1006,     32'hAB,       12'h000, 12'h000, 32'h11223344, 10'd1,  10'd1,  32'h11AB3344, 1'b1,       32'h0,        1'b0);
    drive("lb3",      S_LB,          32'h3,        32'h0,        12'h000, 12'h000, 32'h80000000, 10'd0,  10'd0,  32'h0,        1'b0,       32'hFFFFFF80, 1'b0);
    drive("lbu3",     S_LBU,         32'h3,        32'h0,        12'h000, 12'h000, 32'h80000000, 10'd0,  10'd0,  32'h0,        1'b0,       32'h00000080, 1'b0);
    drive("lh2",      S_LH,          32'h2,        32'h0,        12'h000, 12'h000, 32'h80011234, 10'd0,  10'd0,  32'h0,        1'b0,       32'hFFFF8001, 1'b0);
    drive("lhu2",     S_LHU,         32'h2,        32'h0,        12'h000, 12'h000, 32'h80011234, 10'd0,  10'd0,  32'h0,        1'b0,       32'h00008001, 1'b0);
    drive("lw_wrap",  S_LW,          32'h7FFFFFFC, 32'h0,        12'h004, 12'h000, 32'hCAFEF00D, 10'd0,  10'd0,  32'h0,        1'b0,       32'hCAFEF00D, 1'b0);
    drive("lb_neg",   S_LB,          32'h20,       32'h0,        12'hFFF, 12'h000, 32'h7F000000, 10'd7,  10'd0,  32'h0,        1'b0,       32'h0000007F, 1'b0);
    drive("lhu0",     S_LHU,         32'h0,        32'h0,        12'h000, 12'h000, 32'h0000FFFE, 10'd0,  10'd0,  32'h0,        1'b0,       32'h0000FFFE, 1'b0);
    drive("prio_sw",  S_SW|S_SB|S_LW,32'h8,        32'h13579BDF, 12'h100, 12'h000, 32'hFFFFFFFF, 10'd2,  10'd2,  32'h13579BDF, 1'b1,       32'h0,        1'b0);
    drive("prio_lw",  S_LW|S_LB,     32'h24,       32'h0,        12'h000, 12'h000, 32'h89ABCDEF, 10'd9,  10'd0,  32'h0,        1'b0,       32'h89ABCDEF, 1'b0);
    drive("prio_sh",  S_SH|S_SB,     32'h1,        32'hBEEF,     12'h000, 12'h000, 32'h11223344, 10'd0,  10'd0,  32'h1122BEEF, !MIS,       32'h0,        MIS);
    drive("lh_odd",   S_LH,          32'h3,        32'h0,        12'h000, 12'h000, 32'h80011234, 10'd0,  10'd0,  32'h0,        1'b0,       MIS ? 32'h0 : 32'hFFFF8001, MIS);
    drive("lw_mis",   S_LW,          32'h2,        32'h0,        12'h000, 12'h000, 32'h12345678, 10'd0,  10'd0,  32'h0,        1'b0,       MIS ? 32'h0 : 32'h12345678, MIS);
    drive("sw_mis",   S_SW,          32'h11,       32'hA5A5A5A5, 12'h000, 12'h000, 32'h0,        10'd4,  10'd4,  32'hA5A5A5A5, !MIS,       32'h0,        1'b0 | MIS);
    drive("lw_pre",   S_LW,          32'h40,       32'h0,        12'h000, 12'h000, 32'h12345678, 10'h10, 10'd0,  32'h0,        1'b0,       32'h12345678, 1'b0);

    // Reset in the middle of a load: the held result clears at once.
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("midrst.rd", rd_data, 32'd0);
    strb = S_SB; op1 = 32'd0; op2 = 32'd1; rdata = 32'hAABB_CCDD;
    #1;
    chk("midrst.we", {31'd0, we}, 32'd0);
    chk("midrst.wdata", wdata, 32'hAABB_CC01);
    strb = S_LW; op1 = 32'h0; rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    chk("midrst.hold", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    strb = 8'h00; rdata = 32'd0;
    drive("lw_post",  S_LW,          32'h44,       32'h0,        12'h000, 12'h000, 32'h0BADF00D, 10'h11, 10'd0,  32'h0,        1'b0,       32'h0BADF00D, 1'b0);
    drive("idle_end", 8'h00,         32'h0,        32'h0,        12'h000, 12'h000, 32'h0,        10'd0,  10'd0,  32'h0,        1'b0,       32'h0,        1'b0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- RV32I load/store stage, placed between execute and write-back.
- Computes the effective address and drives a word-organised, asynchronous-read data memory.
- Stores (sb/sh/sw) use read-modify-write on the addressed word.
- Loads (lb/lh/lw/lbu/lhu) extract and extend the addressed lane; the result is registered towards the register file.

Parameters:
- X_LENGTH, 32, datapath width; only 32 is supported.
- MEMORY_DEPTH, 10, word-address width of the data memory.
- MEMORY_WIDTH, 32, memory word width; must equal X_LENGTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-high (asserted at 1).
- rv32_s_sb / rv32_s_sh / rv32_s_sw  in  1 each  store-byte / store-half / store-word decode strobes.
- rv32_i_lb / rv32_i_lh / rv32_i_lw / rv32_i_lbu / rv32_i_lhu  in  1 each  load decode strobes.
- rv32_i_imm_11_0  in  12  I-type load offset, signed.
- rv32_s_imm_11_0  in  12  S-type store offset, signed.
- operand_1  in  X_LENGTH  rs1 base address.
- operand_2  in  X_LENGTH  rs2 store data.
- operand_3  in  X_LENGTH  reserved; ignored.
- write_back_register_rd_data  out  X_LENGTH  registered load result.
- memory_read_address  out  MEMORY_DEPTH  word read address.
- memory_read_data  in  MEMORY_WIDTH  asynchronous read data.
- memory_write_address  out  MEMORY_DEPTH  word write address.
- memory_write_data  out  MEMORY_WIDTH  merged write word.
- memory_write_enable  out  1  write strobe; memory writes on the clk rising edge.

Behaviour:
- Effective address (ea) = operand_1 + sign-extended immediate, modulo 2^32.
  - Stores use rv32_s_imm_11_0; loads use rv32_i_imm_11_0.
  - Word address = ea[MEMORY_DEPTH+1:2]; higher ea bits are discarded.
  - Lane offset = ea[1:0].
- Strobes should be one-hot. If several are asserted, priority is sw > sh > sb > lw > lh > lhu > lb > lbu.
- memory_read_address = word address for any access; 0 when idle.
- Stores:
  - memory_write_address = memory_read_address.
  - memory_write_enable = 1, combinational, same cycle.
  - sb: memory_read_data with byte lane ea[1:0] replaced by operand_2[7:0].
  - sh: half lane ea[1] (bits 15:0 or 31:16) replaced by operand_2[15:0]; ea[0] ignored.
  - sw: operand_2; ea[1:0] ignored.
- Loads:
  - lb/lbu: byte lane ea[1:0], sign-/zero-extended to 32 bits.
  - lh/lhu: half lane ea[1], sign-/zero-extended to 32 bits.
  - lw: full word.
- Idle (no strobe), and during store cycles:
  - memory_write_enable = 0 when idle.
  - memory_write_address = 0 and memory_write_data = 0 when idle.
  - Next write_back_register_rd_data = 0.
- write_back_register_rd_data:
  - Captured on the clk rising edge; 1-cycle latency from load strobe to valid result.
  - Held value is the loaded word for loads, 0 otherwise.
- Reset:
  - While rst_n = 1: write_back_register_rd_data = 0 immediately and memory_write_enable is forced to 0.
  - Combinational address/data outputs are unaffected by reset.
  - A load pending across reset is discarded.
- Reads are combinational from memory_read_data, so no stall and no handshake.

Optional Feature:
- Macro: MEMORY_ACCESS_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output misaligned_fault (1 bit).
  - A half access with ea[0]=1, or a word access with ea[1:0]≠0, is misaligned.
  - A misaligned store forces memory_write_enable = 0.
  - A misaligned load registers rd data 0.
  - misaligned_fault is registered with the same 1-cycle timing as write_back_register_rd_data; reset value 0.
- Without the macro:
  - No extra port.
  - Low address bits are masked as described in Behaviour and the access always proceeds.

Decomposition:
- Shared package holds X_LENGTH, MEMORY_DEPTH and MEMORY_WIDTH constants (matching the global defines).
- One sub-module, load_store_lane_align (purely combinational), computes the byte/half lane merge for stores and the extraction/extension for loads.
- Address adder, priority decode and output register stay in the top module.

Test Plan:
- Reset: assert rst_n=1 mid-load → rd_data 0 at once, write_enable 0; release → next load completes normally.
- sb, operand_1=0, imm 0, operand_2=1, memory_read_data=0xAABBCCDD → addr 0, write_data 0xAABBCC01, write_enable 1; all-zero stimulus next → write_enable 0, write_data 0.
- sh, operand_1=0x102, imm 0, operand_2=0x1234, read 0x11223344 → addr 0x40, write_data 0x12343344.
- sw, operand_1=0x10, imm 0xFFC (−4), operand_2=0xDEADBEEF → addr 3, write_data 0xDEADBEEF.
- lb vs lbu at ea offset 3, read 0x80000000 → next-cycle rd_data 0xFFFFFF80 / 0x00000080; lh vs lhu at offset 2, read 0x8001xxxx → 0xFFFF8001 / 0x00008001.
- lw, operand_1=0x7FFFFFFC, imm 4 (wrap-around) → addr 0, rd_data = read word one cycle later; with MEMORY_ACCESS_MISALIGN_CHECK_EN, lw at ea=2 → misaligned_fault 1, rd_data 0.
